// File: rtl/seq_addsub_pkg.sv
// Shared types and elaboration helpers for the chunked adder/subtractor.
// Optional feature macro used by the top level: SEQ_ADDSUB_SAT_EN.
package seq_addsub_pkg;

    // Controller states: waiting for a request, or stepping through chunks.
    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    localparam int unsigned DefWidth = 16;
    localparam int unsigned DefChunk = 4;

    // Number of chunks processed per operation, which is also the latency in cycles.
    function automatic int unsigned calc_nchunk(input int unsigned width,
                                                input int unsigned chunk);
        return width / chunk;
    endfunction

    // Chunk index counter width; never narrower than one bit.
    function automatic int unsigned calc_idx_w(input int unsigned nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/seq_addsub_chunk_adder.sv
// Combinational CHUNK-bit ripple adder. Also exposes the carry into the
// chunk MSB so the top level can derive signed overflow on the last chunk.
module seq_addsub_chunk_adder #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_x,
    input  logic [CHUNK-1:0] i_y,
    input  logic             i_ci,
    output logic [CHUNK-1:0] o_s,
    output logic             o_co,
    output logic             o_c_msb
);

    logic [CHUNK:0] w_c;

    // Bit-serial ripple: w_c[i] is the carry into bit i.
    always_comb begin
        w_c    = '0;
        o_s    = '0;
        w_c[0] = i_ci;
        for (int i = 0; i < CHUNK; i++) begin
            o_s[i]   = i_x[i] ^ i_y[i] ^ w_c[i];
            w_c[i+1] = (i_x[i] & i_y[i]) | (i_x[i] & w_c[i]) | (i_y[i] & w_c[i]);
        end
    end

    assign o_co    = w_c[CHUNK];
    assign o_c_msb = w_c[CHUNK-1];

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands are summed CHUNK bits per
// clock through a registered carry, under a start/ready/done handshake.
// Optional feature: define SEQ_ADDSUB_SAT_EN for signed saturation of sum on
// overflow; by default sum is the wrapped modular result.
import seq_addsub_pkg::*;

module seq_addsub #(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned CHUNK = DefChunk
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_sub,
    input  logic             i_cin,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_ready,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int unsigned NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int unsigned IDXW   = calc_idx_w(NCHUNK);
    localparam logic [IDXW-1:0] LastIdx = IDXW'(NCHUNK - 1);

    state_e r_state;
    state_e w_state_next;
    logic   w_accept;
    logic   w_last;

    // Captured operands; r_b already holds ~b in subtract mode.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic             r_sub;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_work;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_done;

    int unsigned      w_base;
    logic [CHUNK-1:0] w_x;
    logic [CHUNK-1:0] w_y;
    logic [CHUNK-1:0] w_s;
    logic             w_co;
    logic             w_c_msb;
    logic             w_ovf;
    logic [WIDTH-1:0] w_wrap;
    logic [WIDTH-1:0] w_sum_next;

    // Controller: accept a request while idle, finish after the last chunk.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_state_next = StRun;
                end
            end
            StRun: begin
                if (r_idx == LastIdx) begin
                    w_last       = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Select the active chunk of the captured operands.
    always_comb begin
        w_base = CHUNK * 32'(r_idx);
        w_x    = r_a[w_base +: CHUNK];
        w_y    = r_b[w_base +: CHUNK];
    end

    seq_addsub_chunk_adder #(
        .CHUNK(CHUNK)
    ) u_chunk_adder (
        .i_x    (w_x),
        .i_y    (w_y),
        .i_ci   (r_carry),
        .o_s    (w_s),
        .o_co   (w_co),
        .o_c_msb(w_c_msb)
    );

    // Final result: earlier chunks from the working register, top chunk live.
    always_comb begin
        w_wrap                  = r_work;
        w_wrap[WIDTH-1 -: CHUNK] = w_s;
        w_ovf                   = w_c_msb ^ w_co;
`ifdef SEQ_ADDSUB_SAT_EN
        // Clamp to the signed limit on the side of the captured A operand.
        if (w_ovf) begin
            w_sum_next = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            w_sum_next = w_wrap;
        end
`else
        w_sum_next = w_wrap;
`endif
    end

    // Operand capture and per-chunk working state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
            r_idx   <= '0;
            r_work  <= '0;
        end else if (w_accept) begin
            r_a     <= i_a;
            r_b     <= i_sub ? ~i_b : i_b;
            r_carry <= i_sub ? 1'b1 : i_cin;
            r_sub   <= i_sub;
            r_idx   <= '0;
        end else if (r_state == StRun) begin
            r_work[w_base +: CHUNK] <= w_s;
            r_carry                 <= w_co;
            r_idx                   <= r_idx + 1'b1;
        end
    end

    // Result registers only change on completion; done pulses for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_last) begin
                r_sum  <= w_sum_next;
                r_cout <= w_co;
                r_ovf  <= w_ovf;
            end
        end
    end

    assign o_ready = (r_state == StIdle);
    assign o_done  = r_done;
    assign o_sum   = r_sum;
    assign o_cout  = r_cout;
    assign o_ovf   = r_ovf;

    // r_sub is kept for debug visibility of the captured mode.
    logic w_unused;
    assign w_unused = r_sub;

endmodule

// File: tb/tb_seq_addsub.sv
// Scoreboard bench for seq_addsub (WIDTH=16, CHUNK=4): stimulus pushes the
// expected result, a negedge monitor pops and compares on every done pulse.
module tb_seq_addsub;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic        i_sub;
    logic        i_cin;
    logic [15:0] i_a;
    logic [15:0] i_b;
    logic        o_ready;
    logic        o_done;
    logic [15:0] o_sum;
    logic        o_cout;
    logic        o_ovf;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    seq_addsub #(
        .WIDTH(16),
        .CHUNK(4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_start(i_start),
        .i_sub  (i_sub),
        .i_cin  (i_cin),
        .i_a    (i_a),
        .i_b    (i_b),
        .o_ready(o_ready),
        .o_done (o_done),
        .o_sum  (o_sum),
        .o_cout (o_cout),
        .o_ovf  (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && o_done) begin
            if (q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 with sum=%0h, expected no done", o_sum);
            end else begin
                e = q.pop_front();
                chk("result_sum", 32'(o_sum), 32'(e.sum));
                chk("result_cout", 32'(o_cout), 32'(e.cout));
                chk("result_ovf", 32'(o_ovf), 32'(e.ovf));
            end
        end
    end

    task automatic wait_ready();
        int n;
        @(negedge clk);
        n = 0;
        while (!o_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) chk("wait_ready_timeout", 32'(o_ready), 32'd1);
    endtask

    // Issue one operation and check its start-to-done latency.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                         input logic cin, input logic [15:0] es, input logic ec,
                         input logic eo);
        int cnt;
        wait_ready();
        i_a     = a;
        i_b     = b;
        i_sub   = sub;
        i_cin   = cin;
        i_start = 1'b1;
        q.push_back('{sum: es, cout: ec, ovf: eo});
        @(posedge clk);
        #1;
        i_start = 1'b0;
        cnt = 0;
        while (!o_done && cnt < 10) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("latency", 32'(cnt), 32'd4);
    endtask

    logic [15:0] sat_pos;
    logic [15:0] sat_neg;

    initial begin : stim
        int ndone;
`ifdef SEQ_ADDSUB_SAT_EN
        sat_pos = 16'h7FFF;
        sat_neg = 16'h8000;
`else
        sat_pos = 16'h8000;
        sat_neg = 16'h7FFF;
`endif
        rst_n   = 1'b0;
        i_start = 1'b0;
        i_sub   = 1'b0;
        i_cin   = 1'b0;
        i_a     = '0;
        i_b     = '0;
        #12;
        chk("reset_ready", 32'(o_ready), 32'd1);
        chk("reset_done", 32'(o_done), 32'd0);
        chk("reset_sum", 32'(o_sum), 32'd0);
        chk("reset_cout", 32'(o_cout), 32'd0);
        chk("reset_ovf", 32'(o_ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic add with carry-in.
        do_op(16'h0002, 16'h0002, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0);
        do_op(16'h0002, 16'h0003, 1'b0, 1'b1, 16'h0006, 1'b0, 1'b0);
        // Carry ripples through every chunk; signed overflow.
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, sat_pos, 1'b0, 1'b1);
        // Subtract with borrow, negative overflow, and cin ignored.
        do_op(16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b1, 1'b0, sat_neg, 1'b1, 1'b1);
        do_op(16'h7FFF, 16'hFFFF, 1'b1, 1'b0, sat_pos, 1'b0, 1'b1);
        do_op(16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Start held through RUN with a changing: first capture wins.
        wait_ready();
        i_a     = 16'h0010;
        i_b     = 16'h0001;
        i_sub   = 1'b0;
        i_cin   = 1'b0;
        i_start = 1'b1;
        q.push_back('{sum: 16'h0011, cout: 1'b0, ovf: 1'b0});
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("run_ready_low", 32'(o_ready), 32'd0);
            chk("run_no_done", 32'(o_done), 32'd0);
            i_a = 16'h1000 + 16'(i);
        end
        @(negedge clk);
        chk("hold_done", 32'(o_done), 32'd1);
        chk("done_cycle_ready", 32'(o_ready), 32'd1);
        // Back-to-back start in the done cycle.
        i_a = 16'h0100;
        i_b = 16'h0200;
        q.push_back('{sum: 16'h0300, cout: 1'b0, ovf: 1'b0});
        @(posedge clk);
        #1;
        i_start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (o_done) ndone = i + 1;
        end
        chk("b2b_done_at_4", 32'(ndone), 32'd4);
        chk("b2b_done_now", 32'(o_done), 32'd1);

        // Reset in the second RUN cycle aborts without a done pulse.
        wait_ready();
        i_a     = 16'h00F0;
        i_b     = 16'h000F;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_sum", 32'(o_sum), 32'd0);
        chk("abort_cout", 32'(o_cout), 32'd0);
        chk("abort_ovf", 32'(o_ovf), 32'd0);
        chk("abort_ready", 32'(o_ready), 32'd1);
        chk("abort_done", 32'(o_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (o_done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_addsub.md
Name: seq_addsub

Overview:
Parametrised multi-cycle adder/subtractor. It is the successor to the team's fixed 4-bit combinational adder with carry-in, carry-out and overflow.
- Operand width WIDTH is processed CHUNK bits per clock through a registered carry chain.
- A start/ready/done handshake controls each operation.
- Used in datapaths where a full-width single-cycle carry chain would miss timing.

Parameters:
WIDTH, 16, operand/result width in bits; must be an integer multiple of CHUNK.
CHUNK, 4, bits added per clock; NCHUNK = WIDTH/CHUNK is the latency in cycles.

Ports:
clk  input  1  single clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only while ready=1.
sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1 (cin ignored).
cin  input  1  carry-in for add mode.
a  input  WIDTH  operand A; captured when start is accepted.
b  input  WIDTH  operand B; captured when start is accepted.
ready  output  1  high when IDLE and able to accept start.
done  output  1  one-cycle pulse; result outputs are valid and updated in this cycle.
sum  output  WIDTH  result, two's complement / unsigned.
cout  output  1  carry-out of the MSB. In sub mode 1 = no borrow (a>=b unsigned).
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async assert, sync release): state=IDLE, ready=1, done=0, sum=0, cout=0, ovf=0, internal regs cleared.
- States:
  - IDLE: ready=1. On a clk edge with start=1:
    - capture a, (sub ? ~b : b), carry=(sub ? 1 : cin), and sub.
    - set idx=0 and go to RUN.
  - RUN: ready=0. Each edge adds chunk idx of the captured operands plus the carry register. The chunk result goes into the working register and the chunk carry-out into the carry register; idx then increments.
    - On the edge processing idx=NCHUNK-1:
      - load sum from the working register and final chunk result; load cout and ovf.
      - go to IDLE and pulse done=1 for exactly the following cycle.
- Latency: start accepted at edge k gives done=1 and valid outputs after edge k+NCHUNK.
- Throughput: one operation per NCHUNK cycles.
- sum, cout and ovf hold their last result until the next completion; they do not change during RUN.
- start during RUN is ignored; a and b may change freely during RUN.
- In the done cycle ready=1, so start there is accepted (back-to-back operation).
- Reset mid-RUN aborts the operation: no done pulse, and outputs return to their reset values.
- CHUNK=WIDTH is legal: single-cycle latency, with done following the start edge.

Optional Feature:
SEQ_ADDSUB_SAT_EN:
- Defined: signed saturation. When ovf=1, sum is forced to the signed limit: 0x7F..F if the MSB of a (the captured A) is 0, else 0x80..0. ovf still reports the overflow; cout is unchanged.
- Undefined: sum is the wrapped modular result.

Decomposition:
- Package seq_addsub_pkg holds:
  - the state typedef (IDLE, RUN);
  - the NCHUNK derivation and the width of the idx counter, $clog2(NCHUNK) with a minimum of 1.
- Sub-module chunk_adder: combinational CHUNK-bit ripple adder with inputs x, y, ci and outputs s, co, and c_msb (carry into the chunk MSB, used for ovf on the last chunk).
- The top level owns the FSM, operand and working registers, and output registers.

Test Plan:
All cases use WIDTH=16, CHUNK=4.
1. Add: a=0x0002, b=0x0002, cin=1, sub=0 -> done 4 cycles after start; sum=0x0005, cout=0, ovf=0. Then a=0x0002, b=0x0003, cin=1 -> sum=0x0006.
2. Carry ripple across all chunks: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Signed overflow: a=0x7FFF, b=0x0001 -> sum=0x8000 (0x7FFF with SAT_EN), ovf=1, cout=0.
3. Subtract: a=0x0003, b=0x0005, sub=1 -> sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF (0x8000 with SAT_EN), cout=1, ovf=1.
4. Handshake:
   - Hold start=1 and change a every cycle during RUN -> single done, result from the first-captured operands, ready=0 throughout RUN.
   - Assert start in the done cycle -> second done exactly 4 cycles later.
5. Reset mid-operation: drive rst_n low in the 2nd RUN cycle -> outputs immediately 0, ready=1; no done pulse after release. The next operation completes normally.
